edib_frame_ctrl: RTL and testbench
==================================

EDIB_FRAME_CTRL -- requirements
Module: edib_frame_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of 16-bit payload words buffered (power of 2).
REQ-002 SHALL have parameter MAX_LEN, default 16, largest legal payload length N.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535, maximum Clk cycles between words inside a frame.
REQ-004 Clk  in  1  system clock; all logic on rising edge.
REQ-005 Rstn  in  1  reset, asynchronous, active-low.
REQ-006 RxDone  in  1  receiver word-complete level, Clk domain.
REQ-007 RxType  in  1  word type: 0 command, 1 data.
REQ-008 RxData  in  16  received word, stable while RxDone high.
REQ-009 RxError  in  1  receiver parity error for the current word.
REQ-010 Abort  in  1  synchronous soft abort of the frame in progress.
REQ-011 RdEn  in  1  pop the FIFO head.
REQ-012 RdData  out  16  FIFO head word (first-word-fall-through).
REQ-013 FifoEmpty  out  1  FIFO holds no words.
REQ-014 FifoCount  out  log2(FIFO_DEPTH)+1  words held.
REQ-015 CmdWord  out  16  command word of the current or last frame.
REQ-016 FrameDone  out  1  one-cycle pulse: frame complete.
REQ-017 FrameErr  out  1  one-cycle pulse: frame rejected.
REQ-018 ErrCode  out  3  cause of the last rejection.
REQ-019 Busy  out  1  high in LEN or DATA.

Function
REQ-020 Word strobe SHALL be the rising edge of RxDone, registered once; the FSM acts on the cycle after the edge.
REQ-021 FSM states SHALL be IDLE, LEN, DATA, DONE, ERR.
REQ-022 IDLE: type-0 word -> latch CmdWord, snapshot FIFO write pointer, go LEN; type-1 word -> dropped, no flag.
REQ-023 LEN: type-1 word -> N=RxData; N==0 -> DONE; N>MAX_LEN -> ERR code 2; else load remaining=N, go DATA.
REQ-024 LEN: type-0 word -> resync: new CmdWord, new snapshot, stay LEN.
REQ-025 DATA: type-1 word -> push to FIFO, decrement remaining; remaining reaching 0 -> DONE.
REQ-026 DATA: type-0 word -> ERR code 1.
REQ-027 DATA: push while FIFO full -> word dropped, ERR code 3; fullness is judged before a same-cycle pop.
REQ-028 Timeout counter SHALL clear on every strobe and on entry to LEN; reaching TIMEOUT_CYC in LEN or DATA -> ERR code 0.
REQ-029 DONE and ERR SHALL last exactly one cycle, then go IDLE; FrameDone is asserted in DONE and FrameErr in ERR.
REQ-030 ERR SHALL restore the write pointer to the snapshot, discarding partial payload; complete frames already buffered SHALL be kept.
REQ-031 ErrCode SHALL hold until the next ERR entry.
REQ-032 Abort SHALL force IDLE from any state next cycle, apply the REQ-030 rollback, and assert no FrameErr; Abort has priority over a same-cycle strobe.
REQ-033 RdEn with FifoEmpty SHALL be ignored; simultaneous push and pop SHALL leave FifoCount unchanged.
REQ-034 Pointers SHALL carry one wrap bit; FifoCount = wr-rd modulo 2*FIFO_DEPTH.

Reset
REQ-035 On Rstn low: state IDLE, FIFO empty, CmdWord 0, ErrCode 0, FrameDone/FrameErr/Busy 0, timeout 0, strobe edge register 0.
REQ-036 Reset mid-frame SHALL discard all buffered words, with no pulse after release.

Configuration
REQ-037 Macro EDIB_FRAME_CTRL_PARITY_EN: when defined, a strobe with RxError=1 in LEN or DATA -> ERR code 4, and in IDLE the word is dropped; when undefined, RxError is ignored and code 4 never occurs.

Structure
REQ-038 Package edib_pkg SHALL hold the state encoding, ErrCode constants (TIMEOUT=0, UNEXP_CMD=1, BAD_LEN=2, OVERFLOW=3, PARITY=4) and the default values for FIFO_DEPTH/MAX_LEN.
REQ-039 Storage SHALL be sub-module edib_word_fifo, with pointer snapshot/restore ports.

Verification
REQ-040 cmd 0xA5A5, len 3, data 1,2,3 -> FrameDone once, CmdWord=0xA5A5, FifoCount=3, reads give 1,2,3.
REQ-041 cmd, len 20 (MAX_LEN 16) -> FrameErr, ErrCode=2, FifoCount unchanged.
REQ-042 complete frame len 2, then cmd, len 4, two data words, then cmd -> ErrCode=1, FifoCount=2.
REQ-043 cmd, len 2, one word, then silence for TIMEOUT_CYC -> FrameErr, ErrCode=0, rollback applied.
REQ-044 FIFO at 15 of 16 words, frame len 2 -> ErrCode=3, FifoCount back to 15.
REQ-045 With EDIB_FRAME_CTRL_PARITY_EN defined, a data word with RxError=1 -> ErrCode=4; with the macro undefined, the same stimulus -> FrameDone.

Source files
------------

// File: rtl/edib_pkg.sv
// rtl/edib_pkg.sv - state encoding, rejection codes and default sizes shared by the edib framer
package edib_pkg;

   localparam int DEF_FIFO_DEPTH  = 16;
   localparam int DEF_MAX_LEN     = 16;
   localparam int DEF_TIMEOUT_CYC = 65535;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      ERR_TIMEOUT   = 3'd0,
      ERR_UNEXP_CMD = 3'd1,
      ERR_BAD_LEN   = 3'd2,
      ERR_OVERFLOW  = 3'd3,
      ERR_PARITY    = 3'd4
   } err_code_e;

endpackage

// File: rtl/edib_frame_ctrl_if.sv
// rtl/edib_frame_ctrl_if.sv - receiver word stream and FIFO read port of the edib framer
interface edib_frame_ctrl_if
   import edib_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          RxDone;
   logic          RxType;
   logic [15:0]   RxData;
   logic          RxError;
   logic          RdEn;
   logic [15:0]   RdData;
   logic          FifoEmpty;
   logic [CW-1:0] FifoCount;

   modport master (
      output RxDone, RxType, RxData, RxError, RdEn,
      input  RdData, FifoEmpty, FifoCount
   );

   modport slave (
      input  RxDone, RxType, RxData, RxError, RdEn,
      output RdData, FifoEmpty, FifoCount
   );
endinterface

// File: rtl/edib_word_fifo.sv
// rtl/edib_word_fifo.sv - first-word-fall-through payload FIFO with write-pointer snapshot/restore
module edib_word_fifo
   import edib_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                    Clk,
   input  logic                    Rstn,
   input  logic                    push_i,
   input  logic [15:0]             wdata_i,
   input  logic                    pop_i,
   input  logic                    snap_i,
   input  logic                    restore_i,
   output logic [15:0]             rdata_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [15:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, snap_q;
   logic        do_push, do_pop;

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (count_o == '0);
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & ~full_o & ~restore_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      wr_ptr_d = wr_ptr_q;
      if (restore_i) begin
         // The reader may already have consumed part of the discarded frame; never rewind behind it.
         if ((rd_ptr_d - snap_q) <= (wr_ptr_q - snap_q))
            wr_ptr_d = rd_ptr_d;
         else
            wr_ptr_d = snap_q;
      end else if (do_push) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         snap_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (snap_i)
            snap_q <= wr_ptr_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (do_push)
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/edib_frame_ctrl.sv
// rtl/edib_frame_ctrl.sv - command/length/payload framer feeding a rollback FIFO; parity reject under EDIB_FRAME_CTRL_PARITY_EN
module edib_frame_ctrl
   import edib_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int MAX_LEN     = DEF_MAX_LEN,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              Clk,
   input  logic              Rstn,
   edib_frame_ctrl_if.slave  bus,
   input  logic              Abort,
   output logic [15:0]       CmdWord,
   output logic              FrameDone,
   output logic              FrameErr,
   output logic [2:0]        ErrCode,
   output logic              Busy
);
   localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT_CYC);
   localparam logic [15:0]    MAX_LEN_W = 16'(MAX_LEN);

   state_e        state_q, state_d;
   err_code_e     code_q, code_d, fail_code;
   logic [15:0]   cmd_q, cmd_d, rem_q, rem_d, wdata_q;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          rxdone_q, strobe_q, wtype_q, werr_q;
   logic          perr, fail, push, snap, restore, fifo_full, in_frame;

`ifdef EDIB_FRAME_CTRL_PARITY_EN
   assign perr = werr_q;
`else
   logic unused_werr;
   assign unused_werr = werr_q;
   assign perr        = 1'b0;
`endif

   assign in_frame = (state_q == ST_LEN) || (state_q == ST_DATA);

   // Word is captured together with its strobe so the FSM sees a stable copy one cycle after the edge.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         rxdone_q <= 1'b0;
         strobe_q <= 1'b0;
         wtype_q  <= 1'b0;
         wdata_q  <= '0;
         werr_q   <= 1'b0;
      end else begin
         rxdone_q <= bus.RxDone;
         strobe_q <= bus.RxDone & ~rxdone_q;
         if (bus.RxDone & ~rxdone_q) begin
            wtype_q <= bus.RxType;
            wdata_q <= bus.RxData;
            werr_q  <= bus.RxError;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         state_q <= ST_IDLE;
         code_q  <= ERR_TIMEOUT;
         cmd_q   <= '0;
         rem_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cmd_q   <= cmd_d;
         rem_q   <= rem_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      code_d    = code_q;
      rem_d     = rem_q;
      push      = 1'b0;
      snap      = 1'b0;
      restore   = 1'b0;
      fail      = 1'b0;
      fail_code = ERR_TIMEOUT;
      tmo_d     = (strobe_q || !in_frame) ? '0 : tmo_q + TW'(1);

      case (state_q)
         ST_IDLE: begin
            if (strobe_q && !perr && !wtype_q) begin
               cmd_d   = wdata_q;
               snap    = 1'b1;
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (strobe_q) begin
               if (perr) begin
                  fail      = 1'b1;
                  fail_code = ERR_PARITY;
               end else if (!wtype_q) begin
                  cmd_d = wdata_q;
                  snap  = 1'b1;
               end else if (wdata_q == 16'd0) begin
                  state_d = ST_DONE;
               end else if (wdata_q > MAX_LEN_W) begin
                  fail      = 1'b1;
                  fail_code = ERR_BAD_LEN;
               end else begin
                  rem_d   = wdata_q;
                  state_d = ST_DATA;
               end
            end else if (tmo_q == TMO_LIMIT) begin
               fail = 1'b1;
            end
         end
         ST_DATA: begin
            if (strobe_q) begin
               if (perr) begin
                  fail      = 1'b1;
                  fail_code = ERR_PARITY;
               end else if (!wtype_q) begin
                  fail      = 1'b1;
                  fail_code = ERR_UNEXP_CMD;
               end else if (fifo_full) begin
                  fail      = 1'b1;
                  fail_code = ERR_OVERFLOW;
               end else begin
                  push  = 1'b1;
                  rem_d = rem_q - 16'd1;
                  if (rem_q == 16'd1)
                     state_d = ST_DONE;
               end
            end else if (tmo_q == TMO_LIMIT) begin
               fail = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (fail) begin
         state_d = ST_ERR;
         code_d  = fail_code;
         restore = 1'b1;
      end

      // Abort wins over any word acted on this cycle; only an open frame has anything to roll back.
      if (Abort) begin
         state_d = ST_IDLE;
         cmd_d   = cmd_q;
         code_d  = code_q;
         push    = 1'b0;
         snap    = 1'b0;
         restore = in_frame;
      end
   end

   edib_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Rstn      (Rstn),
      .push_i    (push),
      .wdata_i   (wdata_q),
      .pop_i     (bus.RdEn),
      .snap_i    (snap),
      .restore_i (restore),
      .rdata_o   (bus.RdData),
      .empty_o   (bus.FifoEmpty),
      .full_o    (fifo_full),
      .count_o   (bus.FifoCount)
   );

   assign CmdWord   = cmd_q;
   assign ErrCode   = code_q;
   assign FrameDone = (state_q == ST_DONE);
   assign FrameErr  = (state_q == ST_ERR);
   assign Busy      = in_frame;
endmodule

// File: tb/tb_edib_frame_ctrl.sv
// tb/tb_edib_frame_ctrl.sv - randomized self-checking bench for edib_frame_ctrl against a word-level model
module tb_edib_frame_ctrl;
   localparam int DEPTH = 16;
   localparam int MAXL  = 16;
   localparam int TMO   = 40;
`ifdef EDIB_FRAME_CTRL_PARITY_EN
   localparam bit PARITY_ON = 1'b1;
`else
   localparam bit PARITY_ON = 1'b0;
`endif

   logic        Clk, Rstn, Abort;
   logic [15:0] CmdWord;
   logic        FrameDone, FrameErr, Busy;
   logic [2:0]  ErrCode;

   edib_frame_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

   edib_frame_ctrl #(
      .FIFO_DEPTH  (DEPTH),
      .MAX_LEN     (MAXL),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .Clk       (Clk),
      .Rstn      (Rstn),
      .bus       (bus),
      .Abort     (Abort),
      .CmdWord   (CmdWord),
      .FrameDone (FrameDone),
      .FrameErr  (FrameErr),
      .ErrCode   (ErrCode),
      .Busy      (Busy)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   // Word-level reference: fifo content, how many tail words belong to the open frame, and frame phase.
   logic [15:0] m_q[$];
   int m_pend, m_phase, m_rem, m_cmd, m_code;
   bit m_done, m_err;

   function automatic void m_reset();
      m_q.delete();
      m_pend = 0; m_phase = 0; m_rem = 0; m_cmd = 0; m_code = 0;
      m_done = 0; m_err = 0;
   endfunction

   function automatic void m_pop();
      if (m_q.size() > 0) begin
         if (m_q.size() == m_pend) m_pend--;
         void'(m_q.pop_front());
      end
   endfunction

   function automatic void m_rollback();
      repeat (m_pend) void'(m_q.pop_back());
      m_pend  = 0;
      m_phase = 0;
   endfunction

   function automatic void m_fail(input int code);
      m_rollback();
      m_code = code;
      m_err  = 1;
   endfunction

   function automatic void m_finish();
      m_pend  = 0;
      m_phase = 0;
      m_done  = 1;
   endfunction

   function automatic void m_word(input bit typ, input int d, input bit perr, input bit full_before);
      if (perr && PARITY_ON) begin
         if (m_phase != 0) m_fail(4);
         return;
      end
      case (m_phase)
         0: if (!typ) begin m_cmd = d; m_phase = 1; end
         1: begin
            if (!typ) m_cmd = d;
            else if (d == 0) m_finish();
            else if (d > MAXL) m_fail(2);
            else begin m_rem = d; m_phase = 2; end
         end
         default: begin
            if (!typ) m_fail(1);
            else if (full_before) m_fail(3);
            else begin
               m_q.push_back(16'(d));
               m_pend++;
               m_rem--;
               if (m_rem == 0) m_finish();
            end
         end
      endcase
   endfunction

   task automatic check_outputs();
      check_eq("frame_done", int'(FrameDone), int'(m_done));
      check_eq("frame_err", int'(FrameErr), int'(m_err));
      check_eq("err_code", int'(ErrCode), m_code);
      check_eq("fifo_count", int'(bus.FifoCount), m_q.size());
      check_eq("fifo_empty", int'(bus.FifoEmpty), int'(m_q.size() == 0));
      check_eq("busy", int'(Busy), int'(m_phase != 0));
      check_eq("cmd_word", int'(CmdWord), m_cmd);
   endtask

   task automatic send_word(input bit typ, input logic [15:0] data, input bit perr,
                            input bit pop, input bit abort_now);
      bit full_before;
      @(negedge Clk);
      bus.RxDone = 1'b1; bus.RxType = typ; bus.RxData = data; bus.RxError = perr;
      @(negedge Clk);
      full_before = (m_q.size() == DEPTH);
      if (pop && m_q.size() > 0) check_eq("rd_head", int'(bus.RdData), int'(m_q[0]));
      bus.RdEn = pop;
      Abort    = abort_now;
      @(negedge Clk);
      bus.RdEn = 1'b0; Abort = 1'b0; bus.RxDone = 1'b0; bus.RxError = 1'b0;
      m_done = 0; m_err = 0;
      if (pop) m_pop();
      if (abort_now) m_rollback();
      else m_word(typ, int'(data), perr, full_before);
      check_outputs();
      @(negedge Clk);
      check_eq("pulse_clear", int'(FrameDone | FrameErr), 0);
   endtask

   task automatic send(input bit typ, input logic [15:0] data);
      send_word(typ, data, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rsend(input bit typ, input logic [15:0] data);
      send_word(typ, data, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 59) == 0);
   endtask

   task automatic do_abort();
      @(negedge Clk);
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      m_done = 0; m_err = 0;
      m_rollback();
      check_outputs();
   endtask

   task automatic idle_check_timeout();
      int fired_at = -1;
      for (int i = 0; i < TMO + 10; i++) begin
         @(negedge Clk);
         if (FrameErr && fired_at < 0) fired_at = i;
      end
      if (m_phase != 0) begin
         m_fail(0);
         check_eq("tmo_fired", int'(fired_at >= 0), 1);
         check_eq("tmo_not_early", int'(fired_at >= TMO - 3), 1);
      end else begin
         check_eq("no_tmo", fired_at, -1);
      end
      m_done = 0; m_err = 0;
      check_outputs();
   endtask

   task automatic drain();
      while (m_q.size() > 0) begin
         @(negedge Clk);
         check_eq("drain_head", int'(bus.RdData), int'(m_q[0]));
         bus.RdEn = 1'b1;
         m_pop();
      end
      @(negedge Clk);
      bus.RdEn = 1'b1;
      @(negedge Clk);
      bus.RdEn = 1'b0;
      check_eq("drain_count", int'(bus.FifoCount), 0);
      check_eq("drain_empty", int'(bus.FifoEmpty), 1);
   endtask

   initial begin
      int r, len;
      Clk = 1'b0; Rstn = 1'b0; Abort = 1'b0;
      bus.RxDone = 1'b0; bus.RxType = 1'b0; bus.RxData = '0; bus.RxError = 1'b0; bus.RdEn = 1'b0;
      m_reset();
      repeat (3) @(negedge Clk);
      check_eq("rst_count", int'(bus.FifoCount), 0);
      check_eq("rst_empty", int'(bus.FifoEmpty), 1);
      check_eq("rst_cmd", int'(CmdWord), 0);
      check_eq("rst_code", int'(ErrCode), 0);
      check_eq("rst_done", int'(FrameDone), 0);
      check_eq("rst_err", int'(FrameErr), 0);
      check_eq("rst_busy", int'(Busy), 0);
      Rstn = 1'b1;
      @(negedge Clk);

      send(0, 16'hA5A5); send(1, 3); send(1, 1); send(1, 2); send(1, 3);
      check_eq("t040_cmd", int'(CmdWord), 16'hA5A5);
      check_eq("t040_cnt", int'(bus.FifoCount), 3);
      drain();

      send(0, 16'h1234); send(1, 20);
      check_eq("t041_code", int'(ErrCode), 2);
      check_eq("t041_cnt", int'(bus.FifoCount), 0);

      send(0, 16'h0101); send(1, 2); send(1, 7); send(1, 8);
      send(0, 16'h0202); send(1, 4); send(1, 9); send(1, 10); send(0, 16'h0303);
      check_eq("t042_code", int'(ErrCode), 1);
      check_eq("t042_cnt", int'(bus.FifoCount), 2);

      send(0, 16'h0404); send(1, 2); send(1, 11);
      idle_check_timeout();
      check_eq("t043_code", int'(ErrCode), 0);
      check_eq("t043_cnt", int'(bus.FifoCount), 2);
      drain();

      send(0, 16'h0505); send(1, 15);
      for (int i = 0; i < 15; i++) send(1, 16'(100 + i));
      check_eq("t044_fill", int'(bus.FifoCount), 15);
      send(0, 16'h0606); send(1, 2); send(1, 200); send(1, 201);
      check_eq("t044_code", int'(ErrCode), 3);
      check_eq("t044_cnt", int'(bus.FifoCount), 15);
      drain();

      send(0, 16'h0707); send(1, 1);
      send_word(1, 16'h5555, 1'b1, 1'b0, 1'b0);
      check_eq("t045_cnt", int'(bus.FifoCount), PARITY_ON ? 0 : 1);
      drain();

      send(0, 16'h0808); send(1, 3); send(1, 1);
      do_abort();
      check_eq("abort_cnt", int'(bus.FifoCount), 0);
      send(0, 16'h0909); send(1, 3); send(1, 1); send(1, 2);
      send_word(1, 16'h0003, 1'b0, 1'b0, 1'b1);
      check_eq("abort_strobe_cnt", int'(bus.FifoCount), 0);

      send(0, 16'h0A0A); send(1, 2); send(1, 21); send(1, 22);
      send(0, 16'h0B0B); send(1, 2);
      send_word(1, 16'd23, 1'b0, 1'b1, 1'b0);
      check_eq("pushpop_cnt", int'(bus.FifoCount), 2);
      send(1, 24);
      drain();

      for (int f = 0; f < 120; f++) begin
         if (m_phase == 0 && ($urandom_range(0, 3) == 0 || m_q.size() > 12)) drain();
         if ($urandom_range(0, 9) == 0) rsend(1, 16'($urandom));
         rsend(0, 16'($urandom));
         if ($urandom_range(0, 9) == 0) rsend(0, 16'($urandom));
         r   = $urandom_range(0, 19);
         len = (r == 0) ? 0 : (r < 3) ? MAXL + 1 + $urandom_range(0, 100) : $urandom_range(1, 6);
         if (m_phase != 0) rsend(1, 16'(len));
         for (int k = 0; k < len + 1 && m_phase != 0; k++) begin
            r = $urandom_range(0, 39);
            if (r == 0) rsend(0, 16'($urandom));
            else if (r == 1) do_abort();
            else if (r == 2) idle_check_timeout();
            else rsend(1, 16'($urandom));
         end
      end

      send(0, 16'h0C0C); send(1, 4); send(1, 1); send(1, 2);
      @(negedge Clk);
      Rstn = 1'b0;
      @(negedge Clk);
      m_reset();
      check_eq("midrst_count", int'(bus.FifoCount), 0);
      check_eq("midrst_busy", int'(Busy), 0);
      Rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         check_eq("midrst_no_pulse", int'(FrameDone | FrameErr), 0);
      end
      send(0, 16'h0D0D); send(1, 1); send(1, 16'hBEEF);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
      $fatal(1);
   end
endmodule
